// File: rtl/sdram_ref_pkg.sv
// Shared SDRAM refresh definitions: scheduler FSM encoding and refresh-period constants,
// also used by the refresh period timer so both sides agree on the period and target count.
package sdram_ref_pkg;

  localparam int unsigned REFRESHES_PER_PERIOD = 8192;
  // 64 ms refresh period expressed in system clock cycles (60 MHz)
  localparam int unsigned REF_PERIOD_CYCLES    = 3840000;
  localparam int unsigned STAT_W               = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } ref_state_e;

  // Average spacing between refreshes that meets the per-period target
  function automatic int unsigned ref_interval_cycles();
    return REF_PERIOD_CYCLES / REFRESHES_PER_PERIOD;
  endfunction

endpackage

// File: rtl/ref_stat_counter.sv
// Saturating refresh statistics: periods closed with a deficit and the peak
// number of forced refreshes seen in any single period.
module ref_stat_counter
  import sdram_ref_pkg::*;
#(
  parameter int unsigned W = STAT_W
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         period_end,
  input  logic         period_miss,
  input  logic         force_evt,
  output logic [W-1:0] miss_periods,
  output logic [W-1:0] max_force
);

  localparam logic [W-1:0] SAT = '1;

  logic [W-1:0] force_cnt;

  // A forced request accepted on the boundary cycle is credited to the new period
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      miss_periods <= '0;
      max_force    <= '0;
      force_cnt    <= '0;
    end else begin
      if (period_end) begin
        if (period_miss && (miss_periods != SAT)) miss_periods <= miss_periods + W'(1);
        if (force_cnt > max_force) max_force <= force_cnt;
        force_cnt <= force_evt ? W'(1) : '0;
      end else if (force_evt && (force_cnt != SAT)) begin
        force_cnt <= force_cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh scheduler: counts AUTO REFRESH completions per period and requests refreshes
// (opportunistic or forced) from the command FSM. REF_STAT_EN adds miss_periods/max_force.
module refresh_scheduler #(
  parameter int unsigned REFRESHES_PER_PERIOD = sdram_ref_pkg::REFRESHES_PER_PERIOD,
  parameter int unsigned CNT_W                = 14
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             rst_ref_cnt,
  input  logic             its_fr_time,
  input  logic             bus_idle,
  input  logic             ref_ack,
  input  logic             ref_done,
  output logic             ref_req,
  output logic             ref_force,
  output logic [CNT_W-1:0] ref_cnt,
  output logic             period_ok,
  output logic             missed
`ifdef REF_STAT_EN
  ,
  output logic [15:0]      miss_periods,
  output logic [15:0]      max_force
`endif
);

  import sdram_ref_pkg::*;

  localparam logic [CNT_W-1:0] TARGET = CNT_W'(REFRESHES_PER_PERIOD);

  ref_state_e       state_q, state_d;
  logic             ref_req_d, ref_force_d, period_ok_d, missed_d;
  logic [CNT_W-1:0] ref_cnt_d;
  logic             done_evt;
  logic             short_period;

  assign done_evt     = (state_q == WAIT_DONE) && ref_done;
  assign short_period = rst_ref_cnt && (ref_cnt < TARGET);

  // Next state, refresh accounting and registered output values
  always_comb begin
    state_d     = state_q;
    ref_cnt_d   = ref_cnt;
    missed_d    = missed;
    ref_req_d   = 1'b0;
    ref_force_d = 1'b0;
    period_ok_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && !period_ok && (its_fr_time || bus_idle)) state_d = REQ;
      end
      REQ: begin
        if (ref_ack)                state_d = WAIT_DONE;
        else if (!en && !ref_force) state_d = IDLE;
      end
      WAIT_DONE: begin
        if (ref_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A completion on the boundary cycle belongs to the new period
    if (rst_ref_cnt)                            ref_cnt_d = done_evt ? CNT_W'(1) : '0;
    else if (done_evt && (ref_cnt < TARGET))    ref_cnt_d = ref_cnt + CNT_W'(1);

    if (short_period) missed_d = 1'b1;

    ref_req_d   = (state_d == REQ);
    ref_force_d = (state_d != IDLE) && its_fr_time;
    period_ok_d = (ref_cnt_d == TARGET);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      ref_req   <= 1'b0;
      ref_force <= 1'b0;
      ref_cnt   <= '0;
      period_ok <= 1'b0;
      missed    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_req   <= ref_req_d;
      ref_force <= ref_force_d;
      ref_cnt   <= ref_cnt_d;
      period_ok <= period_ok_d;
      missed    <= missed_d;
    end
  end

`ifdef REF_STAT_EN
  ref_stat_counter #(
    .W(16)
  ) u_stat (
    .clk         (clk),
    .n_rst       (n_rst),
    .period_end  (rst_ref_cnt),
    .period_miss (short_period),
    .force_evt   ((state_q == REQ) && ref_ack && ref_force),
    .miss_periods(miss_periods),
    .max_force   (max_force)
  );
`endif

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench for refresh_scheduler (target count 4): vector table, directed
// handshake sequences and randomized stimulus against a behavioural model.
module tb_refresh_scheduler;

  localparam int unsigned RPP   = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             n_rst, en, rst_ref_cnt, its_fr_time, bus_idle, ref_ack, ref_done;
  logic             ref_req, ref_force, period_ok, missed;
  logic [CNT_W-1:0] ref_cnt;
`ifdef REF_STAT_EN
  logic [15:0]      miss_periods, max_force;
`endif

  int checks = 0;
  int errors = 0;
  bit force_or;

  refresh_scheduler #(
    .REFRESHES_PER_PERIOD(RPP),
    .CNT_W               (CNT_W)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .en          (en),
    .rst_ref_cnt (rst_ref_cnt),
    .its_fr_time (its_fr_time),
    .bus_idle    (bus_idle),
    .ref_ack     (ref_ack),
    .ref_done    (ref_done),
    .ref_req     (ref_req),
    .ref_force   (ref_force),
    .ref_cnt     (ref_cnt),
    .period_ok   (period_ok),
    .missed      (missed)
`ifdef REF_STAT_EN
    ,
    .miss_periods(miss_periods),
    .max_force   (max_force)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic n_rst, en, idle, fr, ack, done, rc;
    logic req, frc;
    int   cnt;
    logic ok, miss;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    force_or |= ref_force;
  endtask

  task automatic idle_inputs();
    en = 1'b0; rst_ref_cnt = 1'b0; its_fr_time = 1'b0;
    bus_idle = 1'b0; ref_ack = 1'b0; ref_done = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    n_rst = 1'b0;
    step();
    step();
    n_rst = 1'b1;
  endtask

  task automatic pulse_period();
    rst_ref_cnt = 1'b1;
    step();
    rst_ref_cnt = 1'b0;
  endtask

  // One full handshake: request, ack two cycles later, done five cycles after ack
  task automatic do_refresh(input bit forced);
    bit got = 1'b0;
    en = 1'b1; its_fr_time = forced; bus_idle = !forced;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (ref_req) got = 1'b1;
    end
    bus_idle = 1'b0;
    if (!got) chk("req_timeout", 32'd0, 32'd1);
    step();
    step();
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("req_drop_after_ack", ref_req, 1'b0);
    repeat (4) step();
    ref_done = 1'b1; its_fr_time = 1'b0;
    step();
    ref_done = 1'b0;
  endtask

  // Behavioural model: phase 0 = nothing pending, 1 = asking, 2 = refresh in flight
  int m_ph, m_cnt;
  bit m_req, m_force, m_missed;

  task automatic model_step();
    bit done_evt;
    int nph;
    if (!n_rst) begin
      m_ph = 0; m_cnt = 0; m_req = 0; m_force = 0; m_missed = 0;
      return;
    end
    done_evt = (m_ph == 2) && ref_done;
    nph = m_ph;
    if (m_ph == 0 && en && m_cnt < RPP && (its_fr_time || bus_idle)) nph = 1;
    else if (m_ph == 1 && ref_ack)             nph = 2;
    else if (m_ph == 1 && !en && !m_force)     nph = 0;
    else if (done_evt)                         nph = 0;
    if (rst_ref_cnt) begin
      if (m_cnt < RPP) m_missed = 1;
      m_cnt = done_evt ? 1 : 0;
    end else if (done_evt && m_cnt < RPP) begin
      m_cnt++;
    end
    m_ph    = nph;
    m_req   = (nph == 1);
    m_force = (nph != 0) && its_fr_time;
  endtask

  initial begin
    bit seen;

    //          n_rst en idle fr ack done rc | req frc cnt ok miss
    vt[0]  = '{1'b0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vt[1]  = '{1'b1, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0};
    vt[2]  = '{1'b1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0};
    vt[3]  = '{1'b1, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0};
    vt[4]  = '{1'b1, 1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0};
    vt[5]  = '{1'b1, 1, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0};
    vt[6]  = '{1'b1, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0};
    vt[7]  = '{1'b1, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 0};
    vt[8]  = '{1'b1, 0, 0, 0, 0, 1, 0,   0, 0, 2, 0, 0};
    vt[9]  = '{1'b1, 1, 1, 0, 0, 0, 0,   1, 0, 2, 0, 0};
    vt[10] = '{1'b1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 0};
    vt[11] = '{1'b1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1};
    vt[12] = '{1'b1, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1};
    vt[13] = '{1'b1, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1};
    vt[14] = '{1'b1, 1, 0, 0, 0, 1, 1,   0, 0, 1, 0, 1};
    vt[15] = '{1'b0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};

    idle_inputs();
    n_rst = 1'b0;
    force_or = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      n_rst = vt[i].n_rst; en = vt[i].en; bus_idle = vt[i].idle; its_fr_time = vt[i].fr;
      ref_ack = vt[i].ack; ref_done = vt[i].done; rst_ref_cnt = vt[i].rc;
      step();
      chk($sformatf("vec%0d_req", i),    ref_req,   vt[i].req);
      chk($sformatf("vec%0d_force", i),  ref_force, vt[i].frc);
      chk($sformatf("vec%0d_cnt", i),    ref_cnt,   vt[i].cnt);
      chk($sformatf("vec%0d_ok", i),     period_ok, vt[i].ok);
      chk($sformatf("vec%0d_missed", i), missed,    vt[i].miss);
    end

    // Four opportunistic refreshes fill the period; no fifth request
    apply_reset();
    force_or = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      do_refresh(1'b0);
      chk($sformatf("fill_cnt%0d", k), ref_cnt, k);
    end
    chk("fill_period_ok", period_ok, 1'b1);
    en = 1'b1; bus_idle = 1'b1; seen = 1'b0;
    repeat (10) begin
      step();
      seen |= ref_req;
    end
    bus_idle = 1'b0;
    chk("fill_no_fifth_req", seen, 1'b0);
    chk("fill_no_force", force_or, 1'b0);
    chk("fill_cnt_sat", ref_cnt, 4);

    // Full period closes clean; short one sets missed; missed is sticky
    pulse_period();
    chk("full_period_missed", missed, 1'b0);
    chk("full_period_cnt", ref_cnt, 0);
    chk("full_period_ok_clr", period_ok, 1'b0);
    do_refresh(1'b0);
    do_refresh(1'b0);
    pulse_period();
    chk("short_period_missed", missed, 1'b1);
    chk("short_period_cnt", ref_cnt, 0);
    for (int k = 0; k < 4; k++) do_refresh(1'b1);
    chk("forced_fill_cnt", ref_cnt, 4);
    pulse_period();
    chk("missed_sticky", missed, 1'b1);

    // Opportunistic request upgraded to forced without dropping ref_req
    apply_reset();
    en = 1'b1; bus_idle = 1'b1;
    step();
    bus_idle = 1'b0;
    chk("upg_req0", ref_req, 1'b1);
    chk("upg_force0", ref_force, 1'b0);
    its_fr_time = 1'b1;
    step();
    chk("upg_req1", ref_req, 1'b1);
    chk("upg_force1", ref_force, 1'b1);
    en = 1'b0;
    step();
    chk("upg_req2_no_withdraw", ref_req, 1'b1);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("upg_wait_force", ref_force, 1'b1);
    its_fr_time = 1'b0; ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    chk("upg_cnt", ref_cnt, 1);
    chk("upg_force_clr", ref_force, 1'b0);

    // Boundary coincident with completion at count 3, then reset mid-request
    apply_reset();
    for (int k = 0; k < 3; k++) do_refresh(1'b0);
    en = 1'b1; bus_idle = 1'b1;
    step();
    bus_idle = 1'b0;
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    step();
    ref_done = 1'b1; rst_ref_cnt = 1'b1;
    step();
    ref_done = 1'b0; rst_ref_cnt = 1'b0;
    chk("coinc_missed", missed, 1'b1);
    chk("coinc_cnt", ref_cnt, 1);
    bus_idle = 1'b1;
    step();
    bus_idle = 1'b0;
    chk("midreq_req", ref_req, 1'b1);
    n_rst = 1'b0;
    step();
    chk("midreq_rst_req", ref_req, 1'b0);
    chk("midreq_rst_missed", missed, 1'b0);
    chk("midreq_rst_cnt", ref_cnt, 0);
    n_rst = 1'b1;

`ifdef REF_STAT_EN
    // Three deficit periods, two forced refreshes in the second
    apply_reset();
    chk("stat_rst_miss", miss_periods, 16'd0);
    chk("stat_rst_max", max_force, 16'd0);
    do_refresh(1'b0);
    pulse_period();
    do_refresh(1'b1);
    do_refresh(1'b1);
    pulse_period();
    pulse_period();
    chk("stat_miss_periods", miss_periods, 16'd3);
    chk("stat_max_force", max_force, 16'd2);
`endif

    // Randomized traffic against the behavioural model
    idle_inputs();
    n_rst = 1'b0;
    model_step();
    step();
    for (int c = 0; c < 3000; c++) begin
      n_rst       = ($urandom_range(199) != 0);
      en          = ($urandom_range(7) != 0);
      bus_idle    = ($urandom_range(3) == 0);
      ref_ack     = ($urandom_range(2) == 0);
      ref_done    = ($urandom_range(3) == 0);
      rst_ref_cnt = ($urandom_range(59) == 0);
      if ($urandom_range(19) == 0) its_fr_time = !its_fr_time;
      model_step();
      step();
      chk($sformatf("rnd%0d_req", c),    ref_req,   m_req);
      chk($sformatf("rnd%0d_force", c),  ref_force, m_force);
      chk($sformatf("rnd%0d_cnt", c),    ref_cnt,   m_cnt);
      chk($sformatf("rnd%0d_ok", c),     period_ok, (m_cnt == RPP));
      chk($sformatf("rnd%0d_missed", c), missed,    m_missed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
